// File: rtl/catv_riscv_core.sv
// catv_riscv_core -- minimal multi-cycle RV32I hart, one instruction in flight.
//
// Optional feature macro: CATV_CSR_EN
//   defined   : CSRRW/S/C (+imm forms) read mhartid, (m)cycle and (m)instret;
//               CSR writes are ignored.
//   undefined : every CSR instruction halts the hart; no counters exist.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   insn_addr_o / insn_valid_o   fetch request (address = PC)
//   insn_ready_i                 fetch request accepted
//   insn_data_i / insn_rvalid_i  fetched word and its valid strobe
//   data_addr_o                  exact (possibly unaligned) load/store address
//   data_wen_o                   1 = store, 0 = load
//   data_wdata_o / data_strb_o   LSB-aligned store data and byte enables
//   data_valid_o / data_ready_i  data request handshake
//   data_rdata_i / data_rvalid_i LSB-aligned load response
//   hartid_i                     20-bit hart id (zero-extended for mhartid)
module catv_riscv_core #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0180
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] insn_addr_o,
    output logic        insn_valid_o,
    input  logic        insn_ready_i,
    input  logic [31:0] insn_data_i,
    input  logic        insn_rvalid_i,
    output logic [31:0] data_addr_o,
    output logic        data_wen_o,
    output logic [31:0] data_wdata_o,
    output logic [3:0]  data_strb_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    output logic        data_valid_o,
    input  logic        data_ready_i,
    input  logic [19:0] hartid_i
);
    typedef enum logic [2:0] {S_FETCH, S_IWAIT, S_EXEC, S_MEM, S_DWAIT, S_HALT} state_t;

    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
    localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13;
    localparam logic [6:0] OP_REG = 7'h33, OP_FENCE = 7'h0F, OP_SYS = 7'h73;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  strb_q, strb_d;
    logic        wen_q, wen_d;
    logic [31:0] rf_q [32];

    logic        wb_en, retire, illegal, insn_vld, data_vld;
    logic [31:0] wb_data;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (f3)
            3'b000:  alu = alt ? a - b : a + b;
            3'b001:  alu = a << sh;
            3'b010:  alu = {31'b0, $signed(a) < $signed(b)};
            3'b011:  alu = {31'b0, a < b};
            3'b100:  alu = a ^ b;
            3'b101:  alu = alt ? $unsigned($signed(a) >>> sh) : a >> sh;
            3'b110:  alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        case (f3)
            3'b000:  br_taken = (a == b);
            3'b001:  br_taken = (a != b);
            3'b100:  br_taken = ($signed(a) < $signed(b));
            3'b101:  br_taken = ($signed(a) >= $signed(b));
            3'b110:  br_taken = (a < b);
            3'b111:  br_taken = (a >= b);
            default: br_taken = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  load_ext = {{24{d[7]}}, d[7:0]};
            3'b001:  load_ext = {{16{d[15]}}, d[15:0]};
            3'b100:  load_ext = {24'b0, d[7:0]};
            3'b101:  load_ext = {16'b0, d[15:0]};
            default: load_ext = d;
        endcase
    endfunction

    // Strobes are never shifted by the address; memory realigns.
    function automatic logic [3:0] size_strb(input logic [1:0] sz);
        case (sz)
            2'b00:   size_strb = 4'b0001;
            2'b01:   size_strb = 4'b0011;
            default: size_strb = 4'b1111;
        endcase
    endfunction

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j, pc_plus4;

    assign opcode   = ir_q[6:0];
    assign rd       = ir_q[11:7];
    assign funct3   = ir_q[14:12];
    assign funct7   = ir_q[31:25];
    assign rs1_v    = rf_q[ir_q[19:15]];
    assign rs2_v    = rf_q[ir_q[24:20]];
    assign imm_i    = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s    = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u    = {ir_q[31:12], 12'b0};
    assign imm_j    = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign pc_plus4 = pc_q + 32'd4;

`ifdef CATV_CSR_EN
    logic [31:0] cycle_q, instret_q, csr_rdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (retire) instret_q <= instret_q + 32'd1;
        end
    end

    always_comb begin
        case (ir_q[31:20])
            12'hF14:          csr_rdata = {12'b0, hartid_i};
            12'hB00, 12'hC00: csr_rdata = cycle_q;
            12'hB02, 12'hC02: csr_rdata = instret_q;
            default:          csr_rdata = '0;
        endcase
    end
`else
    logic unused_hartid;
    assign unused_hartid = ^hartid_i;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        wen_d    = wen_q;
        wb_en    = 1'b0;
        wb_data  = '0;
        retire   = 1'b0;
        illegal  = 1'b0;
        insn_vld = 1'b0;
        data_vld = 1'b0;
        case (state_q)
            S_FETCH: begin
                insn_vld = 1'b1;
                if (insn_ready_i) state_d = S_IWAIT;
            end
            S_IWAIT: begin
                if (insn_rvalid_i) begin
                    ir_d    = insn_data_i;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Default is a retiring non-memory instruction; memory ops and
                // illegal encodings override below.
                state_d = S_FETCH;
                pc_d    = pc_plus4;
                retire  = 1'b1;
                case (opcode)
                    OP_LUI:   begin wb_en = 1'b1; wb_data = imm_u; end
                    OP_AUIPC: begin wb_en = 1'b1; wb_data = pc_q + imm_u; end
                    OP_JAL: begin
                        wb_en = 1'b1; wb_data = pc_plus4; pc_d = pc_q + imm_j;
                    end
                    OP_JALR: begin
                        illegal = (funct3 != 3'b000);
                        wb_en = 1'b1; wb_data = pc_plus4;
                        pc_d = (rs1_v + imm_i) & ~32'd1;
                    end
                    OP_BR: begin
                        illegal = (funct3[2:1] == 2'b01);
                        if (br_taken(funct3, rs1_v, rs2_v)) pc_d = pc_q + imm_b;
                    end
                    OP_LD, OP_ST: begin
                        if (opcode == OP_LD)
                            illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
                        else
                            illegal = funct3[2] || (funct3[1:0] == 2'b11);
                        addr_d  = rs1_v + ((opcode == OP_LD) ? imm_i : imm_s);
                        wen_d   = (opcode == OP_ST);
                        wdata_d = rs2_v;
                        strb_d  = size_strb(funct3[1:0]);
                        pc_d    = pc_q;
                        retire  = 1'b0;
                        state_d = S_MEM;
                    end
                    OP_IMM: begin
                        illegal = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
                                  ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20));
                        wb_en   = 1'b1;
                        wb_data = alu(funct3, (funct3 == 3'b101) && ir_q[30], rs1_v, imm_i);
                    end
                    OP_REG: begin
                        illegal = !((funct7 == 7'h00) ||
                                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
                        wb_en   = 1'b1;
                        wb_data = alu(funct3, ir_q[30], rs1_v, rs2_v);
                    end
                    OP_FENCE: illegal = (funct3[2:1] != 2'b00);
`ifdef CATV_CSR_EN
                    // funct3 0 (ECALL/EBREAK) and 4 (reserved) are not CSR ops.
                    OP_SYS: begin
                        illegal = (funct3[1:0] == 2'b00);
                        wb_en   = 1'b1;
                        wb_data = csr_rdata;
                    end
`endif
                    default: illegal = 1'b1;
                endcase
                if (illegal) begin
                    state_d = S_HALT;
                    pc_d    = pc_q;
                    wb_en   = 1'b0;
                    retire  = 1'b0;
                    addr_d  = addr_q;
                    wen_d   = wen_q;
                    wdata_d = wdata_q;
                    strb_d  = strb_q;
                end
            end
            S_MEM: begin
                data_vld = 1'b1;
                if (data_ready_i) begin
                    if (wen_q) begin
                        pc_d    = pc_plus4;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DWAIT;
                    end
                end
            end
            S_DWAIT: begin
                if (data_rvalid_i) begin
                    wb_en   = 1'b1;
                    wb_data = load_ext(funct3, data_rdata_i);
                    pc_d    = pc_plus4;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            pc_q    <= BOOT_ADDR;
            ir_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            wen_q   <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            wen_q   <= wen_d;
            if (wb_en && (rd != 5'd0)) rf_q[rd] <= wb_data;
        end
    end

    // Requests are suppressed while reset is held, even once the state is FETCH.
    assign insn_valid_o = insn_vld && !rst_i;
    assign data_valid_o = data_vld && !rst_i;
    assign insn_addr_o  = pc_q;
    assign data_addr_o  = addr_q;
    assign data_wen_o   = wen_q;
    assign data_wdata_o = wdata_q;
    assign data_strb_o  = strb_q;
endmodule

// File: tb/tb_catv_riscv_core.sv
module tb_catv_riscv_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] insn_addr, data_addr, data_wdata;
    logic        insn_valid, data_valid, data_wen;
    logic [3:0]  data_strb;
    logic        iready = 1'b1, dready = 1'b1;
    logic        irvalid = 1'b0, drvalid = 1'b0;
    logic [31:0] irdata = '0, drdata = '0;
    logic [19:0] hartid = 20'h5;

    catv_riscv_core dut (
        .clk_i(clk), .rst_i(rst),
        .insn_addr_o(insn_addr), .insn_valid_o(insn_valid), .insn_ready_i(iready),
        .insn_data_i(irdata), .insn_rvalid_i(irvalid),
        .data_addr_o(data_addr), .data_wen_o(data_wen), .data_wdata_o(data_wdata),
        .data_strb_o(data_strb), .data_rvalid_i(drvalid), .data_rdata_i(drdata),
        .data_valid_o(data_valid), .data_ready_i(dready), .hartid_i(hartid)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] OPI = 32'h13, LDO = 32'h03, LUI = 32'h37, AUIPC = 32'h17;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic [31:0] imem [0:1023];
    logic [7:0]  dm   [0:8191];
    logic [31:0] f_addr [0:63];
    int          f_cyc  [0:63];
    logic [31:0] st_addr [0:63], st_data [0:63], ld_addr [0:63];
    logic [3:0]  st_strb [0:63], ld_strb [0:63];
    int          n_f = 0, n_st = 0, n_ld = 0, cyc = 0;
    int          n_checks = 0, n_fail = 0;
    logic [31:0] pcw;
    logic [12:0] da;
    assign da = data_addr[12:0];

    // Bus model: one-cycle responses, fetch/store/load logging.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        irvalid <= 1'b0;
        drvalid <= 1'b0;
        if (rst) begin
            n_f <= 0; n_st <= 0; n_ld <= 0;
        end else begin
            if (insn_valid && iready) begin
                irvalid <= 1'b1;
                irdata  <= imem[insn_addr[11:2]];
                if (n_f < 64) begin f_addr[n_f] <= insn_addr; f_cyc[n_f] <= cyc; end
                n_f <= n_f + 1;
            end
            if (data_valid && dready) begin
                if (data_wen) begin
                    if (n_st < 64) begin
                        st_addr[n_st] <= data_addr; st_data[n_st] <= data_wdata;
                        st_strb[n_st] <= data_strb;
                    end
                    n_st <= n_st + 1;
                end else begin
                    drvalid <= 1'b1;
                    drdata  <= {dm[da + 13'd3], dm[da + 13'd2], dm[da + 13'd1], dm[da]};
                    if (n_ld < 64) begin ld_addr[n_ld] <= data_addr; ld_strb[n_ld] <= data_strb; end
                    n_ld <= n_ld + 1;
                end
            end
        end
    end

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
            input logic [31:0] f3, input logic [31:0] rd, input logic [31:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
            input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
            input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [31:0] rd,
            input logic [31:0] op);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction
    function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
            input logic [31:0] rs1, input logic [31:0] f3, input logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) imem[i] = ECALL;
        for (int i = 0; i < 8192; i++) dm[i] = 8'h00;
        pcw = 32'h180;
    endtask
    task automatic org(input logic [31:0] a);
        pcw = a;
    endtask
    task automatic emit(input logic [31:0] w);
        imem[pcw[11:2]] = w;
        pcw = pcw + 32'd4;
    endtask

    // Reset, run until the hart has been idle for 10 cycles (halted), bounded.
    task automatic run_prog(input int max_cyc, input string name);
        int idle = 0;
        int n = 0;
        iready = 1'b1; dready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        while (idle < 10 && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
            if (!insn_valid && !data_valid) idle++; else idle = 0;
        end
        n_checks++;
        if (idle < 10) begin
            n_fail++;
            $display("FAIL %s_halt_timeout: ran %0d cycles, required halt within %0d", name, n, max_cyc);
        end
    endtask

    task automatic test_store_periph();
        clear_mem();
        emit(enc_i(5, 0, 0, 1, OPI));
        emit(enc_u(32'h80000, 2, LUI));
        emit(enc_s(0, 1, 2, 0));
        run_prog(200, "store");
        n_checks++;
        if (n_st !== 1) begin n_fail++; $display("FAIL store_count: got %0d want 1", n_st); end
        n_checks++;
        if (st_addr[0] !== 32'h8000_0000) begin
            n_fail++; $display("FAIL store_addr: got %h want 80000000", st_addr[0]);
        end
        n_checks++;
        if (st_strb[0] !== 4'b0001) begin n_fail++; $display("FAIL store_strb: got %b want 0001", st_strb[0]); end
        n_checks++;
        if (st_data[0][7:0] !== 8'h05) begin n_fail++; $display("FAIL store_data: got %h want 05", st_data[0][7:0]); end
        n_checks++;
        if (f_addr[3] !== 32'h18C) begin n_fail++; $display("FAIL store_next_fetch: got %h want 0000018c", f_addr[3]); end
        n_checks++;
        if (f_cyc[1] - f_cyc[0] !== 3) begin n_fail++; $display("FAIL alu_timing: got %0d want 3", f_cyc[1] - f_cyc[0]); end
        n_checks++;
        if (f_cyc[3] - f_cyc[2] !== 4) begin n_fail++; $display("FAIL store_timing: got %0d want 4", f_cyc[3] - f_cyc[2]); end
    endtask

    task automatic test_reset();
        iready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (insn_valid !== 1'b0 || data_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valids: got %b%b want 00", insn_valid, data_valid);
        end
        n_checks++;
        if ({data_addr, data_wdata, data_strb, data_wen} !== 69'd0) begin
            n_fail++; $display("FAIL reset_data_outs: addr=%h wdata=%h strb=%b wen=%b want zeros",
                               data_addr, data_wdata, data_strb, data_wen);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (insn_valid !== 1'b1 || insn_addr !== 32'h180) begin
                n_fail++; $display("FAIL reset_fetch_hold%0d: valid=%b addr=%h want 1/00000180", k, insn_valid, insn_addr);
            end
            @(posedge clk); #1;
        end
        iready = 1'b1;
    endtask

    task automatic test_load();
        logic [31:0] exp_v [6];
        logic [31:0] exp_a [5];
        logic [3:0]  exp_s [5];
        exp_v = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h8001_8011, 32'hFFFF_8001};
        exp_a = '{32'h1001, 32'h1001, 32'h1002, 32'h1002, 32'h1000};
        exp_s = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b1111};
        clear_mem();
        dm[13'h1000] = 8'h11; dm[13'h1001] = 8'h80; dm[13'h1002] = 8'h01; dm[13'h1003] = 8'h80;
        emit(enc_u(1, 4, LUI));
        emit(enc_i(1, 4, 0, 3, LDO));
        emit(enc_i(1, 4, 4, 5, LDO));
        emit(enc_i(2, 4, 1, 6, LDO));
        emit(enc_i(2, 4, 5, 7, LDO));
        emit(enc_i(0, 4, 2, 8, LDO));
        emit(enc_s(32'h40, 3, 0, 2));
        emit(enc_s(32'h44, 5, 0, 2));
        emit(enc_s(32'h48, 6, 0, 2));
        emit(enc_s(32'h4C, 7, 0, 2));
        emit(enc_s(32'h50, 8, 0, 2));
        emit(enc_s(32'h60, 6, 0, 1));
        run_prog(400, "load");
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (ld_addr[k] !== exp_a[k] || ld_strb[k] !== exp_s[k]) begin
                n_fail++; $display("FAIL load_req%0d: addr=%h strb=%b want %h/%b", k, ld_addr[k], ld_strb[k], exp_a[k], exp_s[k]);
            end
        end
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (st_data[k] !== exp_v[k]) begin
                n_fail++; $display("FAIL load_value%0d: got %h want %h", k, st_data[k], exp_v[k]);
            end
        end
        n_checks++;
        if (st_strb[5] !== 4'b0011) begin n_fail++; $display("FAIL sh_strb: got %b want 0011", st_strb[5]); end
        n_checks++;
        if (f_cyc[2] - f_cyc[1] !== 5) begin n_fail++; $display("FAIL load_timing: got %0d want 5", f_cyc[2] - f_cyc[1]); end
    endtask

    task automatic test_alu();
        int          regs [13];
        logic [31:0] exp_v [13];
        regs  = '{3, 5, 8, 9, 0, 10, 11, 12, 13, 14, 15, 16, 17};
        exp_v = '{32'hFFFF_FFFE, 32'hF800_0000, 32'h1, 32'h0, 32'h0, 32'h0800_0000, 32'h8000_0000,
                  32'hFFFF_FFFA, 32'h13, 32'hF0, 32'h0000_11BC, 32'h8, 32'h8};
        clear_mem();
        emit(enc_i(3, 0, 0, 1, OPI));
        emit(enc_i(5, 0, 0, 2, OPI));
        emit(enc_r(32'h20, 2, 1, 0, 3));
        emit(enc_u(32'h80000, 4, LUI));
        emit(enc_i(32'h404, 4, 5, 5, OPI));
        emit(enc_i(-1, 0, 0, 6, OPI));
        emit(enc_i(1, 0, 0, 7, OPI));
        emit(enc_r(0, 7, 6, 2, 8));
        emit(enc_r(0, 7, 6, 3, 9));
        emit(enc_i(7, 0, 0, 0, OPI));
        emit(enc_i(4, 4, 5, 10, OPI));
        emit(enc_i(31, 7, 1, 11, OPI));
        emit(enc_r(0, 2, 6, 4, 12));
        emit(enc_i(32'h10, 1, 6, 13, OPI));
        emit(enc_i(32'hF0, 6, 7, 14, OPI));
        emit(enc_u(1, 15, AUIPC));
        emit(enc_r(0, 2, 1, 0, 16));
        emit(enc_i(32'h23, 0, 0, 18, OPI));
        emit(enc_r(0, 18, 7, 1, 17));
        emit(32'h0FF0_000F);
        for (int k = 0; k < 13; k++) emit(enc_s(32'h40 + 4 * k, regs[k], 0, 2));
        run_prog(600, "alu");
        for (int k = 0; k < 13; k++) begin
            n_checks++;
            if (st_data[k] !== exp_v[k]) begin
                n_fail++; $display("FAIL alu_x%0d: got %h want %h", regs[k], st_data[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] exp_f [14];
        exp_f = '{32'h180, 32'h200, 32'h210, 32'h214, 32'h218, 32'h21C, 32'h224,
                  32'h300, 32'h2F8, 32'h2FC, 32'h340, 32'h344, 32'h380, 32'h384};
        clear_mem();
        emit(enc_j(32'h80, 0));
        org(32'h200); emit(enc_b(16, 1, 1, 0));
        org(32'h210);
        emit(enc_i(-1, 0, 0, 9, OPI));
        emit(enc_i(1, 0, 0, 10, OPI));
        emit(enc_b(64, 10, 9, 6));
        emit(enc_b(8, 10, 9, 4));
        org(32'h224); emit(enc_j(32'hDC, 0));
        org(32'h300); emit(enc_j(-8, 5));
        org(32'h2F8); emit(enc_s(32'h40, 5, 0, 2)); emit(enc_j(32'h44, 0));
        org(32'h340); emit(enc_i(32'h381, 0, 0, 11, OPI)); emit(enc_i(0, 11, 0, 12, 32'h67));
        org(32'h380); emit(enc_s(32'h44, 12, 0, 2));
        run_prog(400, "branch");
        n_checks++;
        if (n_f !== 14) begin n_fail++; $display("FAIL branch_fetch_count: got %0d want 14", n_f); end
        for (int k = 0; k < 14; k++) begin
            n_checks++;
            if (f_addr[k] !== exp_f[k]) begin
                n_fail++; $display("FAIL branch_fetch%0d: got %h want %h", k, f_addr[k], exp_f[k]);
            end
        end
        n_checks++;
        if (st_data[0] !== 32'h304) begin n_fail++; $display("FAIL jal_link: got %h want 00000304", st_data[0]); end
        n_checks++;
        if (st_data[1] !== 32'h348) begin n_fail++; $display("FAIL jalr_link: got %h want 00000348", st_data[1]); end
    endtask

    task automatic test_system();
        clear_mem();
        emit(enc_i(1, 0, 0, 1, OPI));
        emit(ECALL);
        emit(enc_s(32'h40, 1, 0, 2));
        run_prog(200, "ecall");
        n_checks++;
        if (n_f !== 2 || n_st !== 0) begin
            n_fail++; $display("FAIL ecall_halt: fetches=%0d stores=%0d want 2/0", n_f, n_st);
        end
        clear_mem();
        emit(32'hFFFF_FFFF);
        run_prog(200, "illegal");
        n_checks++;
        if (n_f !== 1) begin n_fail++; $display("FAIL illegal_halt: fetches=%0d want 1", n_f); end
`ifdef CATV_CSR_EN
        clear_mem();
        emit(enc_i(7, 0, 0, 3, OPI));
        emit(enc_i(32'hF14, 0, 2, 1, 32'h73));
        emit(enc_i(32'hB02, 0, 2, 2, 32'h73));
        emit(enc_i(32'h7C0, 0, 2, 3, 32'h73));
        emit(enc_s(32'h40, 1, 0, 2));
        emit(enc_s(32'h44, 2, 0, 2));
        emit(enc_s(32'h48, 3, 0, 2));
        run_prog(300, "csr");
        n_checks++;
        if (st_data[0] !== 32'h5) begin n_fail++; $display("FAIL csr_mhartid: got %h want 00000005", st_data[0]); end
        n_checks++;
        if (st_data[1] !== 32'h2) begin n_fail++; $display("FAIL csr_minstret: got %h want 00000002", st_data[1]); end
        n_checks++;
        if (st_data[2] !== 32'h0) begin n_fail++; $display("FAIL csr_other: got %h want 00000000", st_data[2]); end
`else
        clear_mem();
        emit(enc_i(32'hF14, 0, 2, 1, 32'h73));
        emit(enc_s(32'h40, 1, 0, 2));
        run_prog(200, "csr");
        n_checks++;
        if (n_f !== 1 || n_st !== 0) begin
            n_fail++; $display("FAIL csr_halt: fetches=%0d stores=%0d want 1/0", n_f, n_st);
        end
`endif
    endtask

    task automatic test_backpressure_reset();
        int w = 0;
        clear_mem();
        emit(enc_u(32'h80000, 2, LUI));
        emit(enc_i(32'h41, 0, 0, 1, OPI));
        emit(enc_s(32'h20, 1, 2, 2));
        iready = 1'b1; dready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        while (!data_valid && w < 40) begin @(posedge clk); #1; w++; end
        n_checks++;
        if (data_valid !== 1'b1) begin n_fail++; $display("FAIL bp_data_valid: got %b want 1", data_valid); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (data_valid !== 1'b1 || insn_valid !== 1'b0 || data_addr !== 32'h8000_0020 ||
                data_wen !== 1'b1 || data_strb !== 4'b1111 || data_wdata !== 32'h41) begin
                n_fail++; $display("FAIL bp_hold%0d: v=%b iv=%b addr=%h wen=%b strb=%b wdata=%h want 1/0/80000020/1/1111/00000041",
                                   k, data_valid, insn_valid, data_addr, data_wen, data_strb, data_wdata);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (data_valid !== 1'b0 || insn_valid !== 1'b0 || data_addr !== 32'h0 || data_strb !== 4'h0) begin
            n_fail++; $display("FAIL midop_reset: dv=%b iv=%b addr=%h strb=%b want 0/0/0/0",
                               data_valid, insn_valid, data_addr, data_strb);
        end
        rst = 1'b0; dready = 1'b1;
        #1;
        n_checks++;
        if (insn_valid !== 1'b1 || insn_addr !== 32'h180) begin
            n_fail++; $display("FAIL midop_refetch: valid=%b addr=%h want 1/00000180", insn_valid, insn_addr);
        end
        w = 0;
        while (n_st == 0 && w < 40) begin @(posedge clk); #1; w++; end
        n_checks++;
        if (n_st !== 1 || st_addr[0] !== 32'h8000_0020) begin
            n_fail++; $display("FAIL bp_store_done: stores=%0d addr=%h want 1/80000020", n_st, st_addr[0]);
        end
    endtask

    initial begin
        test_store_periph();
        test_reset();
        test_load();
        test_alu();
        test_branch();
        test_system();
        test_backpressure_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
